// File: rtl/dmac_pkg.sv
// Shared definitions for the DMAC master: FSM state encoding, register-file
// indices, address increment and the completion status word layout.
package dmac_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned IDX_W   = 4;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned STATE_W = 4;

    // FSM state encoding
    localparam logic [STATE_W-1:0] ST_IDLE    = 4'd0;
    localparam logic [STATE_W-1:0] ST_F_SRC   = 4'd1;
    localparam logic [STATE_W-1:0] ST_F_DST   = 4'd2;
    localparam logic [STATE_W-1:0] ST_F_SIZE  = 4'd3;
    localparam logic [STATE_W-1:0] ST_REQ     = 4'd4;
    localparam logic [STATE_W-1:0] ST_RD      = 4'd5;
    localparam logic [STATE_W-1:0] ST_RD_WAIT = 4'd6;
    localparam logic [STATE_W-1:0] ST_WR      = 4'd7;
    localparam logic [STATE_W-1:0] ST_STATUS  = 4'd8;

    // Register-file indices of the descriptor and status words
    localparam logic [IDX_W-1:0] SRC_IDX_DEF  = 4'd0;
    localparam logic [IDX_W-1:0] DST_IDX_DEF  = 4'd1;
    localparam logic [IDX_W-1:0] SIZE_IDX_DEF = 4'd2;
    localparam logic [IDX_W-1:0] STAT_IDX_DEF = 4'd3;

    localparam logic [ADDR_W-1:0] ADDR_INC_DEF = 32'd4;

    // Status word: done flag in the MSB, words transferred in the low half
    localparam int unsigned STAT_DONE_BIT = 31;

    function automatic logic [DATA_W-1:0] status_word(input logic [CNT_W-1:0] count);
        logic [DATA_W-1:0] w;
        w                = '0;
        w[STAT_DONE_BIT] = 1'b1;
        w[CNT_W-1:0]     = count;
        return w;
    endfunction

endpackage

// File: rtl/dmac_addr_counter.sv
// Source/destination address and remaining-word counters for the DMAC master.
// Ports:
//   clk, reset_n       - clock, async active-low reset
//   load_src/dst/cnt_i - load the respective register from data_i
//   step_i             - advance both addresses and decrement the count
//   data_i             - load data (register file read data)
//   src/dst_nxt_c_o    - next-cycle address values (combinational)
//   cnt_zero_c_o       - next-cycle count is zero (combinational)
module dmac_addr_counter
    import dmac_pkg::*;
#(
    parameter logic [ADDR_W-1:0] ADDR_INC = ADDR_INC_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load_src_i,
    input  logic              load_dst_i,
    input  logic              load_cnt_i,
    input  logic              step_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [ADDR_W-1:0] src_nxt_c_o,
    output logic [ADDR_W-1:0] dst_nxt_c_o,
    output logic              cnt_zero_c_o
);

    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // Next-value selection; address arithmetic wraps modulo 2^32
    always_comb begin
        src_d = src_q;
        dst_d = dst_q;
        cnt_d = cnt_q;
        if (load_src_i) begin
            src_d = data_i;
        end else if (step_i) begin
            src_d = ADDR_W'(src_q + ADDR_INC);
        end
        if (load_dst_i) begin
            dst_d = data_i;
        end else if (step_i) begin
            dst_d = ADDR_W'(dst_q + ADDR_INC);
        end
        if (load_cnt_i) begin
            cnt_d = data_i[CNT_W-1:0];
        end else if (step_i) begin
            cnt_d = CNT_W'(cnt_q - CNT_W'(1));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            src_q <= '0;
            dst_q <= '0;
            cnt_q <= '0;
        end else begin
            src_q <= src_d;
            dst_q <= dst_d;
            cnt_q <= cnt_d;
        end
    end

    // The FSM decides on the value the count is about to take
    assign src_nxt_c_o  = src_d;
    assign dst_nxt_c_o  = dst_d;
    assign cnt_zero_c_o = (cnt_d == '0);

endmodule

// File: rtl/dmac_master.sv
// DMA engine: fetches a descriptor (src, dst, word count) from the register
// file, copies the words over a request/grant bus and writes a status word.
// Ports:
//   clk, reset_n        - clock, async active-low reset
//   op_start            - one-cycle start pulse, honoured only when idle
//   rAddr / rData       - register file read port (rData combinational)
//   wAddr / wData / we  - register file write port
//   m_req/m_grant/m_addr/m_wr/m_dout/m_din - single-master bus
//   busy / done         - operation in progress / last operation finished
// All outputs are registered and decoded from the next state.
module dmac_master
    import dmac_pkg::*;
#(
    parameter logic [IDX_W-1:0]  SRC_IDX  = SRC_IDX_DEF,
    parameter logic [IDX_W-1:0]  DST_IDX  = DST_IDX_DEF,
    parameter logic [IDX_W-1:0]  SIZE_IDX = SIZE_IDX_DEF,
    parameter logic [IDX_W-1:0]  STAT_IDX = STAT_IDX_DEF,
    parameter logic [ADDR_W-1:0] ADDR_INC = ADDR_INC_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              op_start,
    output logic [IDX_W-1:0]  rAddr,
    input  logic [DATA_W-1:0] rData,
    output logic [IDX_W-1:0]  wAddr,
    output logic [DATA_W-1:0] wData,
    output logic              we,
    output logic              m_req,
    input  logic              m_grant,
    output logic [ADDR_W-1:0] m_addr,
    output logic              m_wr,
    output logic [DATA_W-1:0] m_dout,
    input  logic [DATA_W-1:0] m_din,
    output logic              busy,
    output logic              done
);

    logic [STATE_W-1:0] state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [DATA_W-1:0]  data_buf_q, data_buf_d;
    logic               done_q, done_d;

    logic [IDX_W-1:0]   raddr_d, waddr_d;
    logic [DATA_W-1:0]  wdata_d, m_dout_d;
    logic [ADDR_W-1:0]  m_addr_d;
    logic               we_d, m_req_d, m_wr_d, busy_d;

    logic               load_src, load_dst, load_cnt, step;
    logic [ADDR_W-1:0]  src_nxt, dst_nxt;
    logic               cnt_zero;

    dmac_addr_counter #(
        .ADDR_INC (ADDR_INC)
    ) u_addr_counter (
        .clk          (clk),
        .reset_n      (reset_n),
        .load_src_i   (load_src),
        .load_dst_i   (load_dst),
        .load_cnt_i   (load_cnt),
        .step_i       (step),
        .data_i       (rData),
        .src_nxt_c_o  (src_nxt),
        .dst_nxt_c_o  (dst_nxt),
        .cnt_zero_c_o (cnt_zero)
    );

    // Next state, datapath controls and next output values
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        data_buf_d = data_buf_q;
        done_d     = done_q;
        load_src   = 1'b0;
        load_dst   = 1'b0;
        load_cnt   = 1'b0;
        step       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (op_start) begin
                    state_d = ST_F_SRC;
                    done_d  = 1'b0;
                end
            end
            ST_F_SRC: begin
                load_src = 1'b1;
                state_d  = ST_F_DST;
            end
            ST_F_DST: begin
                load_dst = 1'b1;
                state_d  = ST_F_SIZE;
            end
            ST_F_SIZE: begin
                load_cnt = 1'b1;
                count_d  = '0;
                state_d  = cnt_zero ? ST_STATUS : ST_REQ;
            end
            ST_REQ: begin
                if (m_grant) begin
                    state_d = ST_RD;
                end
            end
            ST_RD: begin
                // Grant lost during the read address: retry this word
                state_d = m_grant ? ST_RD_WAIT : ST_REQ;
            end
            ST_RD_WAIT: begin
                data_buf_d = m_din;
                state_d    = ST_WR;
            end
            ST_WR: begin
                step    = 1'b1;
                count_d = CNT_W'(count_q + CNT_W'(1));
                state_d = cnt_zero ? ST_STATUS : ST_RD;
            end
            ST_STATUS: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        raddr_d = '0;
        case (state_d)
            ST_F_SRC:  raddr_d = SRC_IDX;
            ST_F_DST:  raddr_d = DST_IDX;
            ST_F_SIZE: raddr_d = SIZE_IDX;
            default:   raddr_d = '0;
        endcase

        we_d     = (state_d == ST_STATUS);
        waddr_d  = we_d ? STAT_IDX : '0;
        wdata_d  = we_d ? status_word(count_d) : '0;

        m_req_d  = (state_d == ST_REQ) || (state_d == ST_RD) ||
                   (state_d == ST_RD_WAIT) || (state_d == ST_WR);
        m_wr_d   = (state_d == ST_WR);
        m_addr_d = '0;
        if (state_d == ST_RD) begin
            m_addr_d = src_nxt;
        end else if (state_d == ST_WR) begin
            m_addr_d = dst_nxt;
        end
        m_dout_d = m_wr_d ? data_buf_d : '0;
        busy_d   = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            data_buf_q <= '0;
            done_q     <= 1'b0;
            rAddr      <= '0;
            wAddr      <= '0;
            wData      <= '0;
            we         <= 1'b0;
            m_req      <= 1'b0;
            m_addr     <= '0;
            m_wr       <= 1'b0;
            m_dout     <= '0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            data_buf_q <= data_buf_d;
            done_q     <= done_d;
            rAddr      <= raddr_d;
            wAddr      <= waddr_d;
            wData      <= wdata_d;
            we         <= we_d;
            m_req      <= m_req_d;
            m_addr     <= m_addr_d;
            m_wr       <= m_wr_d;
            m_dout     <= m_dout_d;
            busy       <= busy_d;
        end
    end

    assign done = done_q;

endmodule
